// File: rtl/pc_gen_pkg.sv
// Shared types for the fetch-stage program counter generator.
// The return address stack is built only when PC_RAS_EN is defined.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

  typedef enum logic [2:0] {
    NONE     = 3'd0,
    TRAP     = 3'd1,
    BRANCH   = 3'd2,
    MISALIGN = 3'd3,
    RAS      = 3'd4,
    SEQ      = 3'd5
  } pc_cause_e;

  localparam int unsigned DEFAULT_STEP = 32'd4;
  localparam int unsigned STEP_LSB     = $clog2(DEFAULT_STEP);

  // Number of low address bits that must be zero for a given byte step.
  function automatic int unsigned step_lsb(input int unsigned step);
    return $clog2(step);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return address stack; a push while full overwrites the oldest
// entry and the occupancy count saturates at DEPTH.
module pc_ras
  import pc_gen_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] top_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;   // next free slot
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1'b1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == {PTR_W{1'b0}}) ? PTR_LAST : p - PTR_W'(1'b1);
  endfunction

  assign empty_o = (cnt_q == {CNT_W{1'b0}});
  assign full_o  = (cnt_q == CNT_FULL);
  assign top_o   = mem_q[ptr_dec(sp_q)];

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    wr_s  = 1'b0;
    if (clear_i) begin
      sp_d  = {PTR_W{1'b0}};
      cnt_d = {CNT_W{1'b0}};
    end else if (push_i) begin
      wr_s  = 1'b1;
      sp_d  = ptr_inc(sp_q);
      cnt_d = full_o ? cnt_q : cnt_q + CNT_W'(1'b1);
    end else if (pop_i && !empty_o) begin
      sp_d  = ptr_dec(sp_q);
      cnt_d = cnt_q - CNT_W'(1'b1);
    end else begin
      sp_d  = sp_q;
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sp_q  <= {PTR_W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      if (wr_s) begin
        mem_q[sp_q] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-stage PC generator: BOOT/RUN/HALTED control with a prioritised
// redirect network. Define PC_RAS_EN to add the return address stack.
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
  parameter int unsigned     STEP         = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            halt,
  input  logic            resume,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            misaligned,
  output logic [XLEN-1:0] fetch_count
);

  localparam int unsigned     LSB_W     = step_lsb(STEP);
  localparam logic [XLEN-1:0] STEP_MASK = XLEN'((64'd1 << LSB_W) - 64'd1);

  pc_state_e       state_q, state_d;
  pc_cause_e       cause_s;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] seq_pc_s;
  logic            br_misaligned_s;
  logic [XLEN-1:0] ras_top_s;
  logic            ras_empty_s;

  assign seq_pc_s        = pc_q + XLEN'(STEP);
  assign br_misaligned_s = ((br_target & STEP_MASK) != {XLEN{1'b0}});

`ifdef PC_RAS_EN
  logic ras_push_s, ras_pop_s, ras_clear_s, ras_full_unused_s;

  assign ras_push_s  = (cause_s == BRANCH) && ras_push;
  assign ras_pop_s   = (cause_s == RAS);
  // Any accepted trap, from RUN or HALTED, flushes the return predictions.
  assign ras_clear_s = trap && (state_q != BOOT);

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (XLEN)
  ) u_ras (
    .clk_i       (clk),
    .reset_i     (reset),
    .clear_i     (ras_clear_s),
    .push_i      (ras_push_s),
    .push_data_i (seq_pc_s),
    .pop_i       (ras_pop_s),
    .top_o       (ras_top_s),
    .empty_o     (ras_empty_s),
    .full_o      (ras_full_unused_s)
  );
`else
  logic ras_unused_s;

  assign ras_unused_s = ras_push;
  assign ras_top_s    = {XLEN{1'b0}};
  assign ras_empty_s  = 1'b1;
`endif

  // Control FSM: picks the next state and, in RUN, the redirect cause.
  always_comb begin
    state_d = state_q;
    cause_s = NONE;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (trap) begin
          cause_s = TRAP;
        end else if (br_taken) begin
          cause_s = br_misaligned_s ? MISALIGN : BRANCH;
        end else if (halt) begin
          state_d = HALTED;
        end else if (stall) begin
          cause_s = NONE;
        end else if (ras_pop && !ras_empty_s) begin
          cause_s = RAS;
        end else begin
          cause_s = SEQ;
        end
      end
      HALTED: begin
        if (trap || resume) begin
          state_d = RUN;
        end else begin
          state_d = HALTED;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // Next-PC mux; a trap taken out of HALTED carries no RUN cause.
  always_comb begin
    pc_d  = pc_q;
    mis_d = 1'b0;
    case (cause_s)
      TRAP:     pc_d = trap_vector;
      BRANCH:   pc_d = br_target;
      MISALIGN: begin
        pc_d  = trap_vector;
        mis_d = 1'b1;
      end
      RAS:      pc_d = ras_top_s;
      SEQ:      pc_d = seq_pc_s;
      NONE:     pc_d = ((state_q == HALTED) && trap) ? trap_vector : pc_q;
      default:  pc_d = pc_q;
    endcase
  end

  assign cnt_d   = (cause_s != NONE) ? cnt_q + XLEN'(1'b1) : cnt_q;
  assign valid_d = (state_d == RUN);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= {XLEN{1'b0}};
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  assign pc_out      = pc_q;
  assign pc_valid    = valid_q;
  assign misaligned  = mis_q;
  assign fetch_count = cnt_q;

endmodule
